// File: rtl/fifo_pkg.sv
// ============================================================================
// Module     : fifo_pkg
// Description: Pointer types and Gray/binary helpers shared by both FIFO sides.
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef logic [DEFAULT_WIDTH:0] ptr_t;

  // Operands are zero-extended to 32 bits, so one body serves any pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ptr_sync_2ff.sv
// ============================================================================
// Module     : ptr_sync_2ff
// Description: Two-flop synchroniser for a Gray-coded pointer bus.
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

module ptr_sync_2ff #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // Straight flop-to-flop path; safe only because the source changes one bit per step.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/read_handler.sv
// ============================================================================
// Module     : read_handler
// Description: Async FIFO read-domain control: read pointer, write-pointer
//              sync, registered empty / almost_empty / fill count / underflow.
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

module read_handler
  import fifo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int AE_THRESH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rd_en,
  input  logic [WIDTH:0]   wr_ptr_gray,
  output logic [WIDTH-1:0] rd_addr,
  output logic [WIDTH:0]   rd_ptr_gray,
  output logic             empty,
  output logic             almost_empty,
  output logic [WIDTH:0]   rd_count,
  output logic             underflow
);

  localparam logic [WIDTH:0] c_AE_THRESH = (WIDTH+1)'(AE_THRESH);

  logic [WIDTH:0] r_rd_bin;
  logic [WIDTH:0] r_rd_gray;
  logic           r_empty;
  logic           r_almost_empty;
  logic [WIDTH:0] r_rd_count;
  logic           r_underflow;

  logic [WIDTH:0] w_wq2_gray;
  logic [WIDTH:0] w_wq2_bin;
  logic           w_rd_ok;
  logic [WIDTH:0] w_rd_bin_next;
  logic [WIDTH:0] w_rd_gray_next;
  logic [WIDTH:0] w_count_next;

  ptr_sync_2ff #(
    .W (WIDTH+1)
  ) u_wptr_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (wr_ptr_gray),
    .q    (w_wq2_gray)
  );

  assign w_rd_ok        = rd_en & ~r_empty;
  assign w_rd_bin_next  = r_rd_bin + {{WIDTH{1'b0}}, w_rd_ok};
  assign w_rd_gray_next = (WIDTH+1)'(bin2gray(32'(w_rd_bin_next)));
  assign w_wq2_bin      = (WIDTH+1)'(gray2bin(32'(w_wq2_gray)));
  // Lagging write pointer makes this count pessimistic, never optimistic.
  assign w_count_next   = w_wq2_bin - w_rd_bin_next;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_bin       <= '0;
      r_rd_gray      <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_rd_count     <= '0;
      r_underflow    <= 1'b0;
    end else begin
      r_rd_bin       <= w_rd_bin_next;
      r_rd_gray      <= w_rd_gray_next;
      r_empty        <= (w_rd_gray_next == w_wq2_gray);
      r_almost_empty <= (w_count_next <= c_AE_THRESH);
      r_rd_count     <= w_count_next;
      r_underflow    <= rd_en & r_empty;
    end
  end

  assign rd_addr      = r_rd_bin[WIDTH-1:0];
  assign rd_ptr_gray  = r_rd_gray;
  assign empty        = r_empty;
  assign almost_empty = r_almost_empty;
  assign rd_count     = r_rd_count;
  assign underflow    = r_underflow;

endmodule

`default_nettype wire
